// File: rtl/pulse_hs_pkg.sv
// Shared definitions for the pulse req/ack handshake blocks.
// Contents:
//   hs_state_e           - sender FSM states (idle, request high, request low)
//   SYNC_STAGES_DEFAULT  - default depth of the ack synchronizer
//   CNT_W_DEFAULT        - default width of the pending-pulse counter
//   PEND_MAX             - saturation value of the counter at the default width
//   pend_max()           - saturation value for an arbitrary counter width
package pulse_hs_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReqHi = 2'd1,
    StReqLo = 2'd2
  } hs_state_e;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned CNT_W_DEFAULT       = 4;
  localparam int unsigned PEND_MAX            = (32'd1 << CNT_W_DEFAULT) - 32'd1;

  // Largest value a pending counter of the given width can hold.
  function automatic int unsigned pend_max(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// Shared by the send and receive sides of the pulse handshake.
// Parameters:
//   NumStages - number of flops in the chain (at least 2)
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset, clears every stage to 0
//   d_i    - asynchronous input bit
//   q_o    - synchronized output (last stage)
module bit_sync #(
  parameter int unsigned NumStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [NumStages-1:0] sync_q, sync_d;

  // Stage 0 captures the raw input; each later stage copies its predecessor.
  always_comb begin
    sync_d = {sync_q[NumStages-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[NumStages-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// Sender side of a four-phase req/ack pulse-transfer handshake.
// Single-cycle event pulses on sig_a are queued in a saturating pending
// counter and each is delivered as one full req/ack handshake. ack comes from
// another clock domain and is synchronized before the FSM looks at it.
// Parameters:
//   SYNC_STAGES - flops in the ack synchronizer (at least 2)
//   CNT_W       - width of the pending-pulse counter
// Ports:
//   clka     - block clock
//   rst_n    - asynchronous active-low reset
//   sig_a    - event pulse, one event per high cycle
//   ack      - acknowledge from the receiving domain (asynchronous)
//   ovf_clr  - single-cycle clear of overflow
//   req      - request level, driven straight from a flop
//   busy     - a handshake is in flight or events are queued
//   pend_cnt - events queued but not yet launched
//   done     - one-cycle pulse when a handshake completes
//   overflow - sticky, set when an event is dropped at saturation
module pulse_handshake_tx
  import pulse_hs_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             sig_a,
  input  logic             ack,
  input  logic             ovf_clr,
  output logic             req,
  output logic             busy,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             done,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] PendMax = CNT_W'(pend_max(CNT_W));
  localparam logic [CNT_W-1:0] PendOne = CNT_W'(1);

  hs_state_e        state_q, state_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;

  logic ack_s;
  logic pend_nz;
  logic launch;
  logic drop;

  bit_sync #(
    .NumStages(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i (clka),
    .rst_ni(rst_n),
    .d_i   (ack),
    .q_o   (ack_s)
  );

  assign pend_nz = (pend_q != '0);
  assign launch  = (state_q == StIdle) && (sig_a || pend_nz);

  // Handshake sequencing. ack_s is ignored in idle; a stale high ack_s on entry
  // to the request phase simply advances the FSM on the next edge.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = StReqHi;
        end
      end
      StReqHi: begin
        if (ack_s) begin
          state_d = StReqLo;
        end
      end
      StReqLo: begin
        if (!ack_s) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // req mirrors the next state so it comes straight off a flop.
    req_d = (state_d == StReqHi);
  end

  // Pending counter. A launch consumes either the incoming event or a queued
  // one; an event arriving alongside a queued launch takes that slot, so the
  // count is unchanged.
  always_comb begin
    pend_d = pend_q;
    drop   = 1'b0;
    if (launch) begin
      if (pend_nz && !sig_a) begin
        pend_d = pend_q - PendOne;
      end
    end else if (sig_a) begin
      if (pend_q == PendMax) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + PendOne;
      end
    end
  end

  // A drop in the same cycle as a clear leaves overflow set.
  always_comb begin
    ovf_d = drop | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign req      = req_q;
  assign done     = done_q;
  assign pend_cnt = pend_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != StIdle) || pend_nz;

endmodule
